fadd_accum: RTL

- Streaming single-precision reduction stage that sits around the combinational fadd unit.
- Sequences operands into fadd and captures its result (y, ovf) each cycle.
- Accepts a group of IEEE-754 binary32 values delimited by in_last and emits one sum per group.
- Feeds the FPU writeback path via a valid/ready output handshake.

---
 rtl/fadd_accum.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fadd_accum.sv
// -----------------------------------------------------------------------------
// fadd_accum -- streaming binary32 reduction stage.
//
// Accepts a group of IEEE-754 single-precision values, closed by in_last, and
// produces one sum per group on a valid/ready output. The combinational adder
// (fadd) lives in this file as well. It rounds to nearest-even, handles
// subnormals, and returns a canonical quiet NaN (0x7FC00000) for invalid
// operations.
//
// Optional build macro: FADD_ACCUM_OVF_HALT_EN
//   defined   : after an overflow in a group, acc is frozen at the first
//               overflow result. Elements are still accepted and counted.
//   undefined : accumulation continues through fadd after an overflow.
//
// fadd_accum ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_data    in   [31:0] binary32 operand
//   in_valid   in   in_data / in_last valid
//   in_last    in   element closes the current group
//   in_ready   out  element accepted when in_valid & in_ready
//   sum        out  [31:0] group sum
//   sum_ovf    out  sticky overflow flag for the group
//   sum_count  out  [CNT_W-1:0] saturating element count
//   out_valid  out  sum / sum_ovf / sum_count valid
//   out_ready  in   consumer takes the result
//
// fadd ports:
//   x1, x2     in   [31:0] binary32 operands
//   y          out  [31:0] binary32 sum
//   ovf        out  finite operands produced an infinite result
// -----------------------------------------------------------------------------

module fadd (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic        w_a_ge;
    logic [31:0] w_big, w_sml;
    logic [7:0]  w_el, w_es, w_d;
    logic [4:0]  w_dc;
    logic [26:0] w_ml, w_ms, w_msh;
    logic [53:0] w_ext;
    logic        w_sub;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [7:0]  w_lim, w_sh;
    logic [26:0] w_mn;
    logic [9:0]  w_en, w_er;
    logic        w_rup;
    logic [24:0] w_rnd;
    logic [23:0] w_mant;

    // Leading-zero count of a 27-bit vector. An all-zero input returns 27.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign w_a_nan = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    assign w_b_nan = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
    assign w_a_inf = (x1[30:23] == 8'hFF) && (x1[22:0] == 23'd0);
    assign w_b_inf = (x2[30:23] == 8'hFF) && (x2[22:0] == 23'd0);

    // Order the operands by magnitude so that the difference of the
    // significands is never negative. On a tie x1 is the larger operand.
    assign w_a_ge = (x1[30:0] >= x2[30:0]);
    assign w_big  = w_a_ge ? x1 : x2;
    assign w_sml  = w_a_ge ? x2 : x1;

    // A subnormal has effective exponent 1 and no hidden bit.
    assign w_el = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    assign w_es = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
    assign w_ml = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
    assign w_ms = {(w_sml[30:23] != 8'd0), w_sml[22:0], 3'b000};

    // Align the smaller significand. The three low bits are guard, round and
    // sticky. Every bit shifted out is folded into sticky.
    assign w_d   = w_el - w_es;
    assign w_dc  = (w_d > 8'd27) ? 5'd27 : w_d[4:0];
    assign w_ext = {w_ms, 27'd0} >> w_dc;
    assign w_msh = {w_ext[53:28], w_ext[27] | (|w_ext[26:0])};

    assign w_sub = w_big[31] ^ w_sml[31];
    assign w_sum = w_sub ? ({1'b0, w_ml} - {1'b0, w_msh})
                         : ({1'b0, w_ml} + {1'b0, w_msh});

    // The left normalisation shift stops at effective exponent 1. Any result
    // that cannot be normalised further stays subnormal.
    assign w_lz  = lzc27(w_sum[26:0]);
    assign w_lim = w_el - 8'd1;
    assign w_sh  = ({3'd0, w_lz} < w_lim) ? {3'd0, w_lz} : w_lim;

    always_comb begin
        if (w_sum[27]) begin
            w_mn = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_en = {2'b00, w_el} + 10'd1;
        end else begin
            w_mn = w_sum[26:0] << w_sh[4:0];
            w_en = {2'b00, w_el} - {2'b00, w_sh};
        end
    end

    // Round to nearest, ties to even. A carry out of the significand bumps the
    // exponent. This also turns the largest subnormal into the smallest
    // normal value.
    assign w_rup  = w_mn[2] & (w_mn[1] | w_mn[0] | w_mn[3]);
    assign w_rnd  = {1'b0, w_mn[26:3]} + {24'd0, w_rup};
    assign w_er   = w_rnd[24] ? (w_en + 10'd1) : w_en;
    assign w_mant = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];

    always_comb begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (x1[31] != x2[31])))
            y = 32'h7FC0_0000;
        else if (w_a_inf)
            y = {x1[31], 8'hFF, 23'd0};
        else if (w_b_inf)
            y = {x2[31], 8'hFF, 23'd0};
        else if (w_sum == 28'd0)
            // An exact cancellation gives +0. (-0) + (-0) keeps its sign.
            y = {(w_sub ? 1'b0 : w_big[31]), 31'd0};
        else if (w_er >= 10'd255)
            y = {w_big[31], 8'hFF, 23'd0};
        else
            y = {w_big[31], (w_mant[23] ? w_er[7:0] : 8'd0), w_mant[22:0]};
    end

    assign ovf = (x1[30:23] != 8'hFF) && (x2[30:23] != 8'hFF) && (y[30:23] == 8'hFF);

endmodule

module fadd_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      sum,
    output logic             sum_ovf,
    output logic [CNT_W-1:0] sum_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [31:0]      w_y;
    logic             w_ovf;
    logic             w_accept;
    logic             w_halt;

    fadd u_fadd (
        .x1  (r_acc),
        .x2  (in_data),
        .y   (w_y),
        .ovf (w_ovf)
    );

    assign w_accept = in_valid & in_ready;

`ifdef FADD_ACCUM_OVF_HALT_EN
    // Freeze acc at the first overflow result. Later elements are still counted.
    assign w_halt = r_ovf;
`else
    assign w_halt = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= EMPTY;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY, ACC: if (w_accept) w_next = in_last ? DONE : ACC;
            DONE:       if (out_ready) w_next = EMPTY;
            default:    w_next = EMPTY;
        endcase
    end

    // Outputs. The DONE state blocks input, so a result cannot drain in the
    // same cycle that a new group starts.
    always_comb begin
        in_ready  = (r_state != DONE);
        out_valid = (r_state == DONE);
    end

    // Datapath. The first element of a group is loaded directly rather than
    // added to zero, so a lone -0.0 keeps its sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= 32'h0000_0000;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            if (r_state == EMPTY) begin
                r_acc   <= in_data;
                r_count <= CNT_W'(1);
                r_ovf   <= 1'b0;
            end else begin
                r_acc   <= w_halt ? r_acc : w_y;
                r_count <= (r_count == '1) ? r_count : r_count + CNT_W'(1);
                r_ovf   <= r_ovf | w_ovf;
            end
        end
    end

    assign sum       = r_acc;
    assign sum_ovf   = r_ovf;
    assign sum_count = r_count;

endmodule
